// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stall, flush, freeze, statistics and memory-busy watchdog.
// Optional forwarding-aware stall rule selected by the HAZARD_FWD_EN macro.
module hazard_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned BUSY_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_ID_data_RSAddr,
  input  logic [4:0]       i_ID_data_RTAddr,
  input  logic             i_ID_ctrl_UsesRT,
  input  logic [4:0]       i_EX_data_WAddr,
  input  logic             i_EX_ctrl_RegWrite,
  input  logic             i_EX_ctrl_MemRead,
  input  logic [4:0]       i_MEM_data_WAddr,
  input  logic             i_MEM_ctrl_RegWrite,
  input  logic             i_MEM_ctrl_BranchTaken,
  input  logic             i_MEM_ctrl_MemBusy,
  output logic             o_IF_ctrl_PCWrite,
  output logic             o_ID_ctrl_IFIDWrite,
  output logic             o_ID_ctrl_IFIDFlush,
  output logic             o_EX_ctrl_IDEXFlush,
  output logic             o_MEM_ctrl_EXMEMFlush,
  output logic             o_ctrl_Freeze,
  output logic [1:0]       o_ctrl_State,
  output logic [CNT_W-1:0] o_stat_StallCnt,
  output logic [CNT_W-1:0] o_stat_FlushCnt,
  output logic             o_ctrl_Timeout
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } action_t;

  action_t          state_q;
  action_t          action;
  logic             match_ex;
  logic             match_mem;
  logic             dh;
  logic [CNT_W-1:0] busy_cnt;

  always_comb begin
    match_ex  = i_EX_ctrl_RegWrite && (i_EX_data_WAddr != 5'd0) &&
                ((i_EX_data_WAddr == i_ID_data_RSAddr) ||
                 (i_ID_ctrl_UsesRT && (i_EX_data_WAddr == i_ID_data_RTAddr)));
    match_mem = i_MEM_ctrl_RegWrite && (i_MEM_data_WAddr != 5'd0) &&
                ((i_MEM_data_WAddr == i_ID_data_RSAddr) ||
                 (i_ID_ctrl_UsesRT && (i_MEM_data_WAddr == i_ID_data_RTAddr)));
`ifdef HAZARD_FWD_EN
    dh = i_EX_ctrl_MemRead && match_ex;
`else
    dh = match_ex || match_mem;
`endif
  end

  // Next-state is the current cycle's action, chosen by strict priority.
  always_comb begin
    action = RUN;
    if (i_MEM_ctrl_MemBusy)          action = FREEZE;
    else if (i_MEM_ctrl_BranchTaken) action = FLUSH;
    else if (dh)                     action = STALL;
  end

  always_comb begin
    o_IF_ctrl_PCWrite     = 1'b1;
    o_ID_ctrl_IFIDWrite   = 1'b1;
    o_ID_ctrl_IFIDFlush   = 1'b0;
    o_EX_ctrl_IDEXFlush   = 1'b0;
    o_MEM_ctrl_EXMEMFlush = 1'b0;
    o_ctrl_Freeze         = 1'b0;
    if (rst) begin
      o_IF_ctrl_PCWrite     = 1'b0;
      o_ID_ctrl_IFIDWrite   = 1'b0;
      o_ID_ctrl_IFIDFlush   = 1'b1;
      o_EX_ctrl_IDEXFlush   = 1'b1;
      o_MEM_ctrl_EXMEMFlush = 1'b1;
    end else begin
      case (action)
        FREEZE: begin
          o_IF_ctrl_PCWrite   = 1'b0;
          o_ID_ctrl_IFIDWrite = 1'b0;
          o_ctrl_Freeze       = 1'b1;
        end
        FLUSH: begin
          o_ID_ctrl_IFIDFlush   = 1'b1;
          o_EX_ctrl_IDEXFlush   = 1'b1;
          o_MEM_ctrl_EXMEMFlush = 1'b1;
        end
        STALL: begin
          o_IF_ctrl_PCWrite   = 1'b0;
          o_ID_ctrl_IFIDWrite = 1'b0;
          o_EX_ctrl_IDEXFlush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      o_stat_StallCnt <= '0;
      o_stat_FlushCnt <= '0;
      busy_cnt        <= '0;
      o_ctrl_Timeout  <= 1'b0;
    end else begin
      state_q <= action;
      if (action == STALL && o_stat_StallCnt != '1)
        o_stat_StallCnt <= o_stat_StallCnt + CNT_W'(1);
      if (action == FLUSH && o_stat_FlushCnt != '1)
        o_stat_FlushCnt <= o_stat_FlushCnt + CNT_W'(1);
      // Timeout is raised on the same edge the busy count reaches the limit.
      if (action == FREEZE) begin
        if (busy_cnt != CNT_W'(BUSY_LIMIT))
          busy_cnt <= busy_cnt + CNT_W'(1);
        if (busy_cnt >= CNT_W'(BUSY_LIMIT - 1))
          o_ctrl_Timeout <= 1'b1;
      end else begin
        busy_cnt <= '0;
      end
    end
  end

  assign o_ctrl_State = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_hazard_ctrl;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned BUSY_LIMIT = 4;
  localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, usesrt, exrw, exmr, memrw, br, busy;
  logic [4:0] rs, rt, exw, memw;
  logic pcw, ifidw, ifidf, idexf, exmemf, frz, tmo;
  logic [1:0] st;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state
  int unsigned m_state, m_stall, m_flush, m_busy;
  bit          m_tmo;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .BUSY_LIMIT(BUSY_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_ID_data_RSAddr(rs), .i_ID_data_RTAddr(rt), .i_ID_ctrl_UsesRT(usesrt),
    .i_EX_data_WAddr(exw), .i_EX_ctrl_RegWrite(exrw), .i_EX_ctrl_MemRead(exmr),
    .i_MEM_data_WAddr(memw), .i_MEM_ctrl_RegWrite(memrw),
    .i_MEM_ctrl_BranchTaken(br), .i_MEM_ctrl_MemBusy(busy),
    .o_IF_ctrl_PCWrite(pcw), .o_ID_ctrl_IFIDWrite(ifidw), .o_ID_ctrl_IFIDFlush(ifidf),
    .o_EX_ctrl_IDEXFlush(idexf), .o_MEM_ctrl_EXMEMFlush(exmemf), .o_ctrl_Freeze(frz),
    .o_ctrl_State(st), .o_stat_StallCnt(stall_cnt), .o_stat_FlushCnt(flush_cnt),
    .o_ctrl_Timeout(tmo)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit hits(input bit we, input int unsigned wa);
    return we && wa != 0 && (wa == rs || (usesrt && wa == rt));
  endfunction

  // 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE
  function automatic int unsigned model_action();
    bit dh;
`ifdef HAZARD_FWD_EN
    dh = exmr && hits(exrw, exw);
`else
    dh = hits(exrw, exw) || hits(memrw, memw);
`endif
    if (busy) return 3;
    if (br)   return 2;
    if (dh)   return 1;
    return 0;
  endfunction

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, Freeze}
  function automatic logic [5:0] model_ctrl();
    if (rst) return 6'b001110;
    case (model_action())
      3:       return 6'b000001;
      2:       return 6'b111110;
      1:       return 6'b000100;
      default: return 6'b110000;
    endcase
  endfunction

  function automatic void model_update();
    int unsigned a;
    if (rst) begin
      m_state = 0; m_stall = 0; m_flush = 0; m_busy = 0; m_tmo = 0;
    end else begin
      a = model_action();
      m_state = a;
      if (a == 1 && m_stall < CNT_MAX) m_stall++;
      if (a == 2 && m_flush < CNT_MAX) m_flush++;
      if (a == 3) begin
        if (m_busy < BUSY_LIMIT) m_busy++;
        if (m_busy >= BUSY_LIMIT) m_tmo = 1;
      end else begin
        m_busy = 0;
      end
    end
  endfunction

  task automatic step();
    #1;
    check("ctrl", {26'd0, pcw, ifidw, ifidf, idexf, exmemf, frz}, {26'd0, model_ctrl()});
    @(posedge clk);
    model_update();
    #1;
    check("state", {30'd0, st}, m_state);
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
    check("timeout", {31'd0, tmo}, {31'd0, m_tmo});
  endtask

  task automatic idle();
    rst = 0; rs = 0; rt = 0; usesrt = 0; exw = 0; exrw = 0; exmr = 0;
    memw = 0; memrw = 0; br = 0; busy = 0;
  endtask

  initial begin
    int unsigned s0, f0;
    idle();
    m_state = 0; m_stall = 0; m_flush = 0; m_busy = 0; m_tmo = 0;

    // Reset held two cycles with a taken branch present
    rst = 1; br = 1;
    repeat (2) begin
      #1;
      check("rst_pcwrite", {31'd0, pcw}, 32'd0);
      check("rst_flushes", {29'd0, ifidf, idexf, exmemf}, 32'd7);
      step();
    end
    idle();
    check("rst_state", {30'd0, st}, 32'd0);
    check("rst_stall", stall_cnt, 32'd0);
    check("rst_flush", flush_cnt, 32'd0);
    check("rst_tmo", {31'd0, tmo}, 32'd0);
    step();

    // Load-use on rs
    s0 = stall_cnt;
    exrw = 1; exmr = 1; exw = 5; rs = 5;
    step();
    check("loaduse_state", {30'd0, st}, 32'd1);
    exrw = 0; exmr = 0; exw = 0; memrw = 1; memw = 5;
    step();
    memrw = 0; memw = 0;
    step();
`ifdef HAZARD_FWD_EN
    check("loaduse_stalls", stall_cnt - CNT_W'(s0), 32'd1);
`else
    check("loaduse_stalls", stall_cnt - CNT_W'(s0), 32'd2);
`endif
    idle();

    // ALU writer to $8 read via rt: EX then MEM
    s0 = stall_cnt;
    exrw = 1; exw = 8; rt = 8; usesrt = 1;
    step();
    exrw = 0; exw = 0; memrw = 1; memw = 8;
    step();
    memrw = 0; memw = 0;
    step();
`ifdef HAZARD_FWD_EN
    check("alu_stalls", stall_cnt - CNT_W'(s0), 32'd0);
`else
    check("alu_stalls", stall_cnt - CNT_W'(s0), 32'd2);
`endif
    // $0 destination and rt not used: never a hazard
    s0 = stall_cnt;
    exrw = 1; exw = 0; rt = 0; rs = 0; step();
    exw = 8; rt = 8; usesrt = 0; step();
    check("nohaz_stalls", stall_cnt - CNT_W'(s0), 32'd0);
    idle();

    // Branch beats load-use
    s0 = stall_cnt; f0 = flush_cnt;
    br = 1; exrw = 1; exmr = 1; exw = 5; rs = 5;
    step();
    check("br_vs_dh_stall", stall_cnt - CNT_W'(s0), 32'd0);
    check("br_vs_dh_flush", flush_cnt - CNT_W'(f0), 32'd1);
    idle();

    // Busy masks pending branch, then one flush
    f0 = flush_cnt;
    busy = 1; br = 1;
    repeat (3) step();
    check("busy_br_flush", flush_cnt - CNT_W'(f0), 32'd0);
    busy = 0;
    step();
    check("busy_drop_flush", flush_cnt - CNT_W'(f0), 32'd1);
    idle();
    step();

    // Watchdog trips after BUSY_LIMIT freeze edges, stays until reset
    busy = 1;
    repeat (BUSY_LIMIT - 1) step();
    check("wd_early", {31'd0, tmo}, 32'd0);
    step();
    check("wd_trip", {31'd0, tmo}, 32'd1);
    busy = 0;
    repeat (3) step();
    check("wd_sticky", {31'd0, tmo}, 32'd1);
    rst = 1; step();
    check("wd_cleared", {31'd0, tmo}, 32'd0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(99) < 2);
      rs     = 5'($urandom_range(3));
      rt     = 5'($urandom_range(3));
      usesrt = 1'($urandom);
      exw    = 5'($urandom_range(3));
      exrw   = ($urandom_range(99) < 60);
      exmr   = ($urandom_range(99) < 40);
      memw   = 5'($urandom_range(3));
      memrw  = ($urandom_range(99) < 60);
      br     = ($urandom_range(99) < 15);
      busy   = (i % 400 >= 200 && i % 400 < 206) || ($urandom_range(99) < 20);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It watches register addresses and control bits from ID, EX and MEM, plus the branch outcome and memory-busy status from MEM. From these it drives PC write-enable, IF/ID hold/flush, ID/EX bubble, EX/MEM flush and a global freeze. It also keeps stall/flush statistics and a memory-busy watchdog.

## Interface
- CNT_W, 16, width of statistics counters
- BUSY_LIMIT, 255, consecutive freeze cycles before watchdog trips (1..2^CNT_W-1)

Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- i_ID_data_RSAddr  in  5  rs of instruction in ID
- i_ID_data_RTAddr  in  5  rt of instruction in ID
- i_ID_ctrl_UsesRT  in  1  ID instruction reads rt as a source (R-type, sw, beq)
- i_EX_data_WAddr  in  5  destination after RegDst mux, EX stage
- i_EX_ctrl_RegWrite  in  1  EX instruction writes a register
- i_EX_ctrl_MemRead  in  1  EX instruction is a load
- i_MEM_data_WAddr  in  5  destination, MEM stage
- i_MEM_ctrl_RegWrite  in  1  MEM instruction writes a register
- i_MEM_ctrl_BranchTaken  in  1  branch in MEM resolved taken
- i_MEM_ctrl_MemBusy  in  1  data memory not ready this cycle
- o_IF_ctrl_PCWrite  out  1  PC register load enable
- o_ID_ctrl_IFIDWrite  out  1  IF/ID register load enable
- o_ID_ctrl_IFIDFlush  out  1  IF/ID load NOP
- o_EX_ctrl_IDEXFlush  out  1  ID/EX load bubble (all ctrl bits 0)
- o_MEM_ctrl_EXMEMFlush  out  1  EX/MEM load bubble
- o_ctrl_Freeze  out  1  all pipeline registers (incl. MEM/WB) hold
- o_ctrl_State  out  2  registered state: 0 RUN, 1 STALL, 2 FLUSH, 3 FREEZE
- o_stat_StallCnt  out  CNT_W  data-stall cycles since reset
- o_stat_FlushCnt  out  CNT_W  taken-branch flushes since reset
- o_ctrl_Timeout  out  1  sticky watchdog flag

## Operation
- Hazard match terms:
  - matchEX = RegWrite_EX && WAddr_EX != 0 && (WAddr_EX == RS || (UsesRT && WAddr_EX == RT)).
  - matchMEM uses the same terms for the MEM stage.
  - Register $0 never causes a hazard.
- Data hazard (dh) depends on the configuration (see Configuration).
- Per-cycle action, strict priority:
  1. FREEZE, if MemBusy: Freeze=1, PCWrite=0, IFIDWrite=0, all flushes 0. A pending branch is not acted on; it is re-evaluated when busy drops.
  2. FLUSH, if BranchTaken: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1, EXMEMFlush=1. dh is ignored because the ID instruction is squashed.
  3. STALL, if dh: PCWrite=0, IFIDWrite=0, IDEXFlush=1, other flushes 0.
  4. RUN: PCWrite=1, IFIDWrite=1, all flushes 0, Freeze=0.
- The state register loads the action code each cycle; o_ctrl_State shows the previous cycle's action.
- o_stat_StallCnt increments on each STALL cycle. o_stat_FlushCnt increments on each FLUSH cycle. Both saturate at 2^CNT_W-1 and do not wrap.
- Busy counter:
  - Increments on each FREEZE cycle and clears on any non-FREEZE cycle.
  - When it reaches BUSY_LIMIT, o_ctrl_Timeout is set.
  - Timeout stays set until rst; the counter saturates.
  - Freeze behaviour is unchanged after the watchdog trips.

## Timing
- All hazard/control outputs are combinational from the current inputs (Mealy), with zero-cycle latency. The pipeline registers sample them on the same clk edge.
- State, counters and timeout update on the rising edge.
- While rst=1:
  - PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1, EXMEMFlush=1, Freeze=0.
  - Next edge loads State=0, both counters=0, busy counter=0, Timeout=0.
- rst asserted mid-stall or mid-freeze overrides all inputs that cycle. The first cycle after release evaluates normally.
- Load-use stall lasts exactly 1 cycle with forwarding. Without forwarding, a RAW stall lasts 1–2 cycles.
- Register file is write-before-read, so the WB stage never needs a stall.

## Configuration
- HAZARD_FWD_EN defined: forwarding unit present. dh = MemRead_EX && matchEX. MEM-stage and non-load EX writers do not stall.
- HAZARD_FWD_EN undefined: no forwarding. dh = matchEX || matchMEM, for any writer including loads.

## Test plan
- Reset: hold rst=1 for 2 cycles with BranchTaken=1. Required: PCWrite=0, all three flushes=1. After release: State=0, StallCnt=0, FlushCnt=0, Timeout=0.
- Load-use, FWD_EN defined: EX MemRead=1, RegWrite=1, WAddr=5; ID RS=5. Required: one cycle with PCWrite=0, IFIDWrite=0, IDEXFlush=1. Then RUN, with StallCnt=1 and State=1 for one cycle.
- No forwarding: EX add writing $8, ID RT=8 with UsesRT=1. Required: STALL while $8 is in EX and again while it is in MEM (StallCnt=2), then RUN. Repeat with WAddr=0 and UsesRT=0 → no stall.
- Branch vs hazard: BranchTaken=1 and a load-use match in the same cycle. Required: FLUSH (all three flushes=1, PCWrite=1), StallCnt unchanged, FlushCnt+1.
- Busy over branch: MemBusy=1 for 3 cycles with BranchTaken=1. Required: Freeze=1, no flush, FlushCnt unchanged. When busy drops: one FLUSH cycle, FlushCnt+1.
- Watchdog with BUSY_LIMIT=4: MemBusy=1 for 4 cycles → Timeout=1 after the 4th edge. Then drop busy → Timeout stays 1 until rst.
